wptr_full: RTL and testbench
============================

Name: wptr_full

Overview:
Write-domain pointer and full-flag logic for the team's dual-clock Gray-pointer FIFO. It is the write-side counterpart of the read-pointer/empty block.
- Keeps the binary and Gray write pointers and drives the RAM write address.
- Compares the next Gray pointer against the read pointer after it has been synchronized into the write clock domain. From this it produces full, almost-full, a write-side occupancy count and a sticky overflow flag.
- Sits between the FIFO write client, the dual-port RAM and the write-to-read pointer synchronizer.

Parameters:
- ADDRSIZE, 4, RAM address width. FIFO depth = 2**ADDRSIZE. Legal range is 2 or more.
- AFULL_THRESH, 12, occupancy at or above which walmost_full asserts. Legal range is 1 to 2**ADDRSIZE.

Ports:
- wclk  input  1  write-domain clock; all state changes on its rising edge.
- wrst_n  input  1  reset; synchronous and active-low, sampled on the wclk rising edge.
- winc  input  1  write request for this cycle.
- wq2_rptr  input  ADDRSIZE+1  read Gray pointer, already synchronized into wclk.
- woverflow_clr  input  1  clears the sticky overflow flag.
- waddr  output  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
- wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wr_count  output  ADDRSIZE+1  write-side occupancy, combinational from registers.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (wrst_n=0 at a wclk edge):
  - wbin, wptr, waddr, wr_count, woverflow = 0; wfull = 0; walmost_full = 0.
  - Reset mid-operation discards all state at that edge. There is no asynchronous path.
- Accept: wbnext = wbin + (winc & ~wfull). A write while full is dropped and the pointers hold.
- Gray conversion: wgnext = (wbnext >> 1) ^ wbnext. wbin <= wbnext and wptr <= wgnext every cycle.
- Wrap-around: arithmetic is modulo 2**(ADDRSIZE+1). The MSB is the wrap bit.
- Full: wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - The write that fills the FIFO raises wfull at the same edge it is accepted. Latency is 0 cycles after that edge.
  - Deassertion is pessimistic: wfull clears at the first wclk edge after wq2_rptr advances.
- Count:
  - rbin_s = gray2bin(wq2_rptr).
  - wr_count = wbin - rbin_s, modulo 2**(ADDRSIZE+1). Legal range is 0 to 2**ADDRSIZE.
  - The count is an upper bound, because the read pointer lags by the synchronizer delay.
- Almost full: walmost_full <= ((wbnext - rbin_s) >= AFULL_THRESH). It is registered and updated with the same timing as wfull.
- Overflow (woverflow):
  - Sets on (winc & wfull).
  - Clears on woverflow_clr.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous write and read-pointer advance: both take effect together. The flags use wbnext and the current wq2_rptr.
- Constraint: wq2_rptr changes by at most one Gray step per wclk. This is guaranteed by the synchronizer; no checking is required.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDRSIZE;
  - functions bin2gray and gray2bin, parameterized on ADDRSIZE+1 bits.
  - The read-side block uses the same package.
- No sub-module. The block is a single module of roughly 120–160 lines.

Test Plan:
All scenarios use ADDRSIZE=4 and AFULL_THRESH=12.
- Reset: hold wrst_n=0 for 2 edges with winc=1 -> wptr=0, waddr=0, wfull=0, walmost_full=0, woverflow=0, wr_count=0. Release with winc=0 -> all values stay 0.
- Fill: wq2_rptr=0, 16 consecutive winc -> waddr steps 0..15, then 0.
  - walmost_full=1 from the edge accepting the 12th write.
  - wfull=1 from the edge accepting the 16th write.
  - wptr=5'b11000, wr_count=16.
- Overflow: while full, winc=1 for 3 cycles -> wptr stays 5'b11000 and woverflow=1.
  - woverflow_clr=1 alone -> woverflow=0.
  - woverflow_clr=1 together with winc=1 while full -> woverflow stays 1.
- Drain release: from full, set wq2_rptr=5'b00001 -> wfull=0 at the next edge and wr_count=15. A write at the next edge -> wfull=1 again.
- Wrap: 40 writes with wq2_rptr tracking gray(wbin-2) -> wfull is never set, wr_count=2 throughout.
  - After write 32: wbin wraps to 0, wptr=5'b00000, waddr=0.
  - After write 40: wptr=gray(8)=5'b01100.
- Reset mid-fill: after 10 writes, pulse wrst_n=0 for one edge -> all outputs return to reset values at that edge. The next write uses waddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock Gray-pointer FIFO: default sizing and
// binary/Gray conversion helpers used by both the write and read pointer blocks.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int GRAY_MAX_W   = 32;

    // Callers zero-extend into GRAY_MAX_W and truncate back to ADDRSIZE+1 bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bus of the FIFO: client request, synchronized read pointer in,
// RAM address, Gray pointer and status flags out.
interface wptr_full_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                woverflow_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wr_count;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, woverflow_clr,
        input  waddr, wptr, wfull, walmost_full, wr_count, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, woverflow_clr,
        output waddr, wptr, wfull, walmost_full, wr_count, woverflow
    );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and full/almost-full logic of the dual-clock FIFO.
// Flags are computed from the next pointer so a filling write raises wfull at its own edge.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = ADDRSIZE_DEF,
    parameter int AFULL_THRESH = 12
) (
    input  logic        wclk,
    input  logic        wrst_n,
    wptr_full_if.slave  bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AFULL_W = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;

    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_ptr_s;
    logic          accept_s;

    // Next-state computation for pointers and flags.
    always_comb begin
        rbin_s         = PW'(gray2bin(GRAY_MAX_W'(bus.wq2_rptr)));
        accept_s       = bus.winc & ~wfull_q;
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, accept_s};
        wptr_d         = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
        // Full when the next pointer is one lap ahead: top two Gray bits inverted.
        full_ptr_s     = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
        wfull_d        = (wptr_d == full_ptr_s);
        walmost_full_d = ((wbin_d - rbin_s) >= AFULL_W);
        if (bus.winc & wfull_q) begin
            woverflow_d = 1'b1;
        end else if (bus.woverflow_clr) begin
            woverflow_d = 1'b0;
        end else begin
            woverflow_d = woverflow_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wr_count     = wbin_q - rbin_s;
    assign bus.woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: the driver queues the expected post-edge
// outputs for each cycle, a monitor pops and compares them after every edge.
module tb_wptr_full;
    import fifo_pkg::*;

    typedef struct {
        logic [63:0] tag;
        logic [3:0]  waddr;
        logic [4:0]  wptr;
        logic        wfull;
        logic        walmost_full;
        logic [4:0]  wr_count;
        logic        woverflow;
    } exp_t;

    logic wclk;
    logic wrst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    wptr_full_if #(.ADDRSIZE(4)) bus ();

    wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic exp_t mk(input logic [63:0] tag, input int waddr, input logic [4:0] wptr,
                                input logic full, input logic af, input int cnt, input logic ovf);
        exp_t e;
        e.tag          = tag;
        e.waddr        = 4'(waddr);
        e.wptr         = wptr;
        e.wfull        = full;
        e.walmost_full = af;
        e.wr_count     = 5'(cnt);
        e.woverflow    = ovf;
        return e;
    endfunction

    task automatic drive(input logic rst_n, input logic inc, input logic clr,
                         input logic [4:0] rq, input exp_t e);
        @(negedge wclk);
        wrst_n            = rst_n;
        bus.winc          = inc;
        bus.woverflow_clr = clr;
        bus.wq2_rptr      = rq;
        sb.push_back(e);
    endtask

    // Monitor: every edge presents a new output set; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.waddr !== e.waddr || bus.wptr !== e.wptr || bus.wfull !== e.wfull ||
                    bus.walmost_full !== e.walmost_full || bus.wr_count !== e.wr_count ||
                    bus.woverflow !== e.woverflow) begin
                    errors++;
                    $display("FAIL %0s got waddr=%0d wptr=%b full=%b af=%b cnt=%0d ovf=%b exp waddr=%0d wptr=%b full=%b af=%b cnt=%0d ovf=%b",
                             e.tag, bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wr_count, bus.woverflow,
                             e.waddr, e.wptr, e.wfull, e.walmost_full, e.wr_count, e.woverflow);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        checks            = 0;
        errors            = 0;
        wrst_n            = 1'b0;
        bus.winc          = 1'b0;
        bus.woverflow_clr = 1'b0;
        bus.wq2_rptr      = 5'b00000;

        // Reset held with writes requested, then released idle.
        drive(1'b0, 1'b1, 1'b0, 5'b00000, mk("rst", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 5'b00000, mk("rst", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 5'b00000, mk("idle", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 5'b00000, mk("idle", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));

        // Fill: almost-full from the 12th write, full from the 16th.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'b00000,
                  mk("fill", i % 16, g(i), (i == 16), (i >= 12), i, 1'b0));
        end

        // Writes while full are dropped and set the sticky overflow.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'b00000, mk("ovf", 0, 5'b11000, 1'b1, 1'b1, 16, 1'b1));
        end
        drive(1'b1, 1'b0, 1'b1, 5'b00000, mk("ovfclr", 0, 5'b11000, 1'b1, 1'b1, 16, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 5'b00000, mk("setwins", 0, 5'b11000, 1'b1, 1'b1, 16, 1'b1));

        // Read pointer advances by one: full drops, then one write refills.
        drive(1'b1, 1'b0, 1'b0, 5'b00001, mk("drain", 0, 5'b11000, 1'b0, 1'b1, 15, 1'b1));
        drive(1'b1, 1'b1, 1'b0, 5'b00001, mk("refill", 1, 5'b11001, 1'b1, 1'b1, 16, 1'b1));

        // Wrap: read pointer trails by two, 40 writes cross the pointer wrap.
        drive(1'b0, 1'b0, 1'b1, g(30), mk("wraprst", 0, 5'b00000, 1'b0, 1'b0, 2, 1'b0));
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 1'b0, g((k + 31) % 32),
                  mk("wrap", (k + 1) % 16, g((k + 1) % 32), 1'b0, 1'b0, 2, 1'b0));
        end
        drive(1'b1, 1'b0, 1'b0, g(7), mk("wrapend", 8, 5'b01100, 1'b0, 1'b0, 1, 1'b0));

        // Reset in the middle of a fill discards everything at that edge.
        drive(1'b0, 1'b0, 1'b0, 5'b00000, mk("midrst0", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'b00000, mk("mid", i, g(i), 1'b0, 1'b0, i, 1'b0));
        end
        drive(1'b0, 1'b1, 1'b0, 5'b00000, mk("midrst", 0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
        drive(1'b1, 1'b1, 1'b0, 5'b00000, mk("post", 1, 5'b00001, 1'b0, 1'b0, 1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 5'b00000, mk("postidle", 1, 5'b00001, 1'b0, 1'b0, 1, 1'b0));

        waits = 0;
        while (sb.size() > 0 && waits < 20) begin
            @(negedge wclk);
            waits++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0 pending", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
